rv32_trap_csr_unit: RTL and testbench
=====================================

Name: rv32_trap_csr_unit

Overview:
Parametrised machine-mode CSR and trap controller for the rv32im multicycle core. It replaces the core's inline fixed 8-line interrupt and CSR logic. It owns mstatus, mie, mip, mtvec, mepc, mcause and mscratch, and arbitrates N local interrupts, a timer interrupt, ecall and ebreak. The core queries it at each instruction boundary and gets back a take/target decision; it also handles mret and the WFI sleep wait.

Parameters:
NUM_IRQ, 16, number of local interrupt lines (1..16); line k maps to mip/mie bit 16+k and interrupt cause 16+k.
IRQ_EDGE_MASK, 16'h0000, per-line mode; bit k = 1 makes line k edge-triggered (latched), 0 makes it level-sensitive.
RESET_MTVEC, 32'h0110_0000, mtvec value at reset (direct mode).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
irq_i  in  NUM_IRQ  local interrupt requests, asynchronous to software
timer_irq_i  in  1  machine timer request (MTIP, mip bit 7), level
csr_en_i  in  1  one-cycle CSR access strobe from EXECUTE
csr_op_i  in  2  00 read-only, 01 write, 10 set, 11 clear
csr_addr_i  in  12  CSR address
csr_wdata_i  in  32  operand, already selected by the core (rs1 or zimm)
csr_rdata_o  out  32  combinational read data for csr_addr_i
csr_illegal_o  out  1  csr_en_i asserted with an unimplemented address
trap_check_i  in  1  core is at an instruction boundary (DECODE)
insn_pc_i  in  32  PC of the instruction in DECODE
ecall_i  in  1  decoded ecall, qualified by trap_check_i
ebreak_i  in  1  decoded ebreak, qualified by trap_check_i
mret_i  in  1  one-cycle mret strobe
wfi_i  in  1  one-cycle wfi strobe
trap_take_o  out  1  combinational; redirect to trap_pc_o this cycle
trap_pc_o  out  32  trap target
mret_pc_o  out  32  equals mepc
irq_pending_o  out  1  (mip & mie) != 0
wfi_sleep_o  out  1  core must stall while this is high
csr_mip_o  out  32  mip mirror
csr_mie_o  out  32  mie mirror

Behaviour:
Clock and reset:
- One clock, clk_i.
- rst_i is synchronous and active-high.
- Reset values: mstatus 0, mie 0, mip 0, mtvec RESET_MTVEC, mepc 0, mcause 0, mscratch 0, FSM in RUN, wfi_sleep_o 0.
- trap_take_o is forced to 0 while rst_i is high.

Interrupt sampling:
- irq_i and timer_irq_i are registered once (irq_q).
- Level line: mip bit = irq_q bit, so latency is 1 cycle.
- Edge line: the pending bit sets when irq_q is 1 and its previous sample was 0, so latency is 2 cycles. It stays set until software clears it via a write or clear to mip. If set and clear land in the same cycle, set wins.
- Level bits and MTIP are read-only in mip.

Eligibility and priority:
- eligible = mip & mie, gated by mstatus.MIE (bit 3).
- Priority: lowest local index first, then timer.

Trap decision (combinational, when trap_check_i is high):
- Any eligible interrupt: take it with mcause = {1, cause}. The instruction is not executed.
- Otherwise ecall: take it with mcause = 11.
- Otherwise ebreak: take it with mcause = 3.
- trap_take_o is high in all three cases.

Trap update (on the next edge after trap_take_o):
- mepc <= {insn_pc_i[31:2], 2'b00}.
- mcause updated.
- MPIE (bit 7) <= MIE; MIE <= 0.

Trap target:
- Exceptions, or mtvec mode 00: {mtvec[31:2], 00}.
- Interrupts with mode 01: base + 4*cause.
- mtvec[1] is hardwired to 0.

mret:
- MIE <= MPIE; MPIE <= 1.
- The core loads mret_pc_o.

CSR write rules:
- New value: op 01 = wdata; op 10 = old | wdata; op 11 = old & ~wdata; op 00 = no write.
- mstatus: only bits 3 and 7 are writable; all other bits read 0.
- mie: only bit 7 and bits 16..16+NUM_IRQ-1 are writable.
- mip: only edge-type local bits are writable.
- mepc: bits [1:0] read 0.
- mcause and mscratch: fully writable.
- Addresses: 0x300, 0x304, 0x305, 0x340, 0x341, 0x342, 0x344. Any other address reads 0 and raises csr_illegal_o; the write is dropped.

FSM:
- RUN -> WFI_WAIT on wfi_i. wfi_sleep_o = 1 in WFI_WAIT.
- WFI_WAIT -> RUN when (mip & mie) != 0, regardless of mstatus.MIE. wfi_sleep_o falls on the same edge.
- rst_i during WFI_WAIT -> RUN.

Simultaneous events:
- Trap with CSR write or mret in the same cycle: trap updates win per field.
- CSR write to mstatus with mret: mret wins on bits 3 and 7.

Optional Feature:
RV32_TRAP_COUNTERS_EN
- Defined: adds a 64-bit mcycle counter that increments every cycle and resets to 0.
  - 0xB00/0xB80 read and write the low and high halves; a written half takes the written value that cycle instead of incrementing.
  - 0xC00/0xC80 are read-only aliases.
  - The low-to-high carry wraps at 2^64.
- Undefined: those addresses are unimplemented (read 0, csr_illegal_o).

Decomposition:
- Package rv32_csr_pkg:
  - CSR address constants.
  - mcause codes: 2, 3, 7, 11, 16+.
  - mstatus bit indices MIE and MPIE.
  - csr_op encoding.
  - FSM state constants.
- Sub-module rv32_irq_pending: input registers, edge detect, pending register, mie masking, priority encoder producing a valid flag and cause.

Test Plan:
- Level line: mie = 0x10000, mstatus = 0x8, irq_i[0] pulsed high for 3 cycles, trap_check_i high at insn_pc 0x0100_0040 -> trap_take_o = 1, mcause = 0x8000_0010, mepc = 0x0100_0040, mstatus = 0x80.
- Vectored mode: mtvec = 0x0110_0001, irq_i[3] and timer both pending and enabled -> trap_pc_o = 0x0110_004C (cause 19 wins over 7).
- Edge line: IRQ_EDGE_MASK = 1, 1-cycle pulse on irq_i[0] -> mip bit 16 set 2 cycles later and held; csrrc mip with 0x10000 -> bit cleared; set and clear in the same cycle -> bit stays 1.
- ecall at 0x0100_0100 with mstatus.MIE = 0 -> mcause = 11, target = mtvec base; then mret -> mret_pc_o = 0x0100_0100, MIE restored, MPIE = 1.
- WFI: wfi_i with mstatus.MIE = 0 -> wfi_sleep_o = 1; timer_irq_i with mie = 0x80 -> sleep drops, no trap taken; rst_i mid-wait -> wfi_sleep_o = 0 next cycle.
- Illegal and masked writes: write 0x7B1 -> csr_illegal_o = 1, read 0; csrrw mstatus with 0xFFFF_FFFF -> reads back 0x88.

Source files
------------

// File: rtl/rv32_csr_pkg.sv
// Shared constants for the rv32im machine-mode trap/CSR unit: CSR addresses,
// mcause codes, mstatus bit positions, CSR op encoding and trap FSM states.
package rv32_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

  localparam logic [4:0] CAUSE_ILLEGAL_INSN = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT   = 5'd3;
  localparam logic [4:0] CAUSE_M_TIMER      = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_M      = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL_BASE   = 5'd16;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WFI_WAIT = 1'b1
  } trap_state_e;

  // Read-modify-write result of a CSR instruction before field masking
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_v,
                                            logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old_v | wdata;
      CSR_OP_CLEAR: return old_v & ~wdata;
      default:      return old_v;
    endcase
  endfunction

endpackage

// File: rtl/rv32_trap_csr_unit_irq_pending.sv
// Interrupt front end: registers the request lines, detects rising edges on
// edge-type lines, holds their pending bits, masks with mie and picks the
// highest-priority eligible interrupt (lowest local line, then timer).
module rv32_irq_pending
  import rv32_csr_pkg::*;
#(
  parameter int          NUM_IRQ       = 16,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               timer_irq_i,
  input  logic [31:0]        mie_i,
  input  logic               gie_i,
  input  logic               mip_we_i,
  input  logic [NUM_IRQ-1:0] mip_wdata_i,
  output logic [31:0]        mip_o,
  output logic               pending_o,
  output logic               irq_valid_o,
  output logic [4:0]         irq_cause_o
);

  localparam logic [NUM_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] irq_q, irq_prev_q, edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] local_mip, elig_local;
  logic               timer_q, elig_timer;

  // Sample the asynchronous lines once; the previous sample feeds edge detect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q       <= '0;
      irq_prev_q  <= '0;
      timer_q     <= 1'b0;
      edge_pend_q <= '0;
    end else begin
      irq_q       <= irq_i;
      irq_prev_q  <= irq_q;
      timer_q     <= timer_irq_i;
      edge_pend_q <= edge_pend_d;
    end
  end

  // Software write/clear first, then a new rising edge ORs in so set wins
  always_comb begin
    edge_pend_d = mip_we_i ? mip_wdata_i : edge_pend_q;
    edge_pend_d = (edge_pend_d | (irq_q & ~irq_prev_q)) & EDGE;
  end

  assign local_mip = (irq_q & ~EDGE) | (edge_pend_q & EDGE);

  // Assemble the architectural mip view
  always_comb begin
    mip_o                 = '0;
    mip_o[16 +: NUM_IRQ]  = local_mip;
    mip_o[7]              = timer_q;
  end

  assign pending_o  = |(mip_o & mie_i);
  assign elig_local = local_mip & mie_i[16 +: NUM_IRQ] & {NUM_IRQ{gie_i}};
  assign elig_timer = timer_q & mie_i[7] & gie_i;

  // Timer is lowest priority; scanning lines downward leaves the lowest index
  always_comb begin
    irq_valid_o = elig_timer;
    irq_cause_o = CAUSE_M_TIMER;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (elig_local[k]) begin
        irq_valid_o = 1'b1;
        irq_cause_o = CAUSE_LOCAL_BASE + 5'(k);
      end
    end
  end

endmodule

// File: rtl/rv32_trap_csr_unit.sv
// Machine-mode CSR file and trap controller for the rv32im multicycle core.
// Owns mstatus/mie/mip/mtvec/mepc/mcause/mscratch, decides traps at each
// instruction boundary, handles mret and the WFI sleep wait.
// Optional: define RV32_TRAP_COUNTERS_EN to add the 64-bit mcycle counter.
module rv32_trap_csr_unit
  import rv32_csr_pkg::*;
#(
  parameter int          NUM_IRQ       = 16,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000,
  parameter logic [31:0] RESET_MTVEC   = 32'h0110_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               timer_irq_i,
  input  logic               csr_en_i,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_illegal_o,
  input  logic               trap_check_i,
  input  logic [31:0]        insn_pc_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               mret_i,
  input  logic               wfi_i,
  output logic               trap_take_o,
  output logic [31:0]        trap_pc_o,
  output logic [31:0]        mret_pc_o,
  output logic               irq_pending_o,
  output logic               wfi_sleep_o,
  output logic [31:0]        csr_mip_o,
  output logic [31:0]        csr_mie_o
);

  localparam logic [31:0] LOCAL_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << 16;
  localparam logic [31:0] MIE_WMASK  = LOCAL_MASK | 32'h0000_0080;

  logic        mst_mie_q, mst_mpie_q;
  logic [31:0] mie_q, mtvec_q, mepc_q, mcause_q, mscratch_q;
  logic [31:0] mip, mstatus_rd, csr_new, trap_cause, trap_base;
  logic        csr_hit, csr_wr, irq_valid, irq_pending;
  logic [4:0]  irq_cause;
  trap_state_e state_q;
  logic        wfi_sleep_q;

`ifdef RV32_TRAP_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_inc;
  assign mcycle_inc = mcycle_q + 64'd1;
`endif

  rv32_irq_pending #(
    .NUM_IRQ       (NUM_IRQ),
    .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
  ) u_irq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_i       (irq_i),
    .timer_irq_i (timer_irq_i),
    .mie_i       (mie_q),
    .gie_i       (mst_mie_q),
    .mip_we_i    (csr_wr && csr_addr_i == CSR_MIP),
    .mip_wdata_i (csr_new[16 +: NUM_IRQ]),
    .mip_o       (mip),
    .pending_o   (irq_pending),
    .irq_valid_o (irq_valid),
    .irq_cause_o (irq_cause)
  );

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[MSTATUS_MIE]  = mst_mie_q;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie_q;
  end

  // Combinational CSR read mux; unknown addresses read 0 and flag csr_hit low
  always_comb begin
    csr_rdata_o = '0;
    csr_hit     = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = mstatus_rd;
      CSR_MIE:      csr_rdata_o = mie_q;
      CSR_MTVEC:    csr_rdata_o = mtvec_q;
      CSR_MSCRATCH: csr_rdata_o = mscratch_q;
      CSR_MEPC:     csr_rdata_o = mepc_q;
      CSR_MCAUSE:   csr_rdata_o = mcause_q;
      CSR_MIP:      csr_rdata_o = mip;
`ifdef RV32_TRAP_COUNTERS_EN
      CSR_MCYCLE,  CSR_CYCLE:  csr_rdata_o = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: csr_rdata_o = mcycle_q[63:32];
`endif
      default:      csr_hit = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_en_i & ~csr_hit;
  assign csr_wr        = csr_en_i & csr_hit & (csr_op_i != CSR_OP_READ);
  assign csr_new       = csr_apply(csr_op_e'(csr_op_i), csr_rdata_o, csr_wdata_i);

  // Trap decision: interrupts beat ecall, ecall beats ebreak
  assign trap_take_o = ~rst_i & trap_check_i & (irq_valid | ecall_i | ebreak_i);
  assign trap_cause  = irq_valid ? {1'b1, 26'd0, irq_cause}
                     : ecall_i   ? {27'd0, CAUSE_ECALL_M}
                     :             {27'd0, CAUSE_BREAKPOINT};
  assign trap_base   = mtvec_q & ~32'h3;
  assign trap_pc_o   = (irq_valid && mtvec_q[1:0] == 2'b01)
                     ? trap_base + {25'd0, irq_cause, 2'b00} : trap_base;

  assign mret_pc_o     = mepc_q;
  assign irq_pending_o = irq_pending;
  assign wfi_sleep_o   = wfi_sleep_q;
  assign csr_mip_o     = mip;
  assign csr_mie_o     = mie_q;

  // CSR state: software writes, then mret, then trap; later ones win per field
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
    end else begin
      if (csr_wr) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mst_mie_q  <= csr_new[MSTATUS_MIE];
            mst_mpie_q <= csr_new[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q      <= csr_new & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= csr_new & ~32'h2;
          CSR_MSCRATCH: mscratch_q <= csr_new;
          CSR_MEPC:     mepc_q     <= csr_new & ~32'h3;
          CSR_MCAUSE:   mcause_q   <= csr_new;
          default: ;
        endcase
      end
      if (mret_i) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end
      if (trap_take_o) begin
        mepc_q     <= insn_pc_i & ~32'h3;
        mcause_q   <= trap_cause;
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
      end
    end
  end

  // WFI wait: sleep until any enabled interrupt pends, ignoring mstatus.MIE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      wfi_sleep_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: if (wfi_i) begin
          state_q     <= ST_WFI_WAIT;
          wfi_sleep_q <= 1'b1;
        end
        ST_WFI_WAIT: if (irq_pending) begin
          state_q     <= ST_RUN;
          wfi_sleep_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_RUN;
          wfi_sleep_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RV32_TRAP_COUNTERS_EN
  // Free-running cycle counter; a written half replaces its increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q <= '0;
    end else begin
      mcycle_q <= mcycle_inc;
      if (csr_wr && csr_addr_i == CSR_MCYCLE)  mcycle_q[31:0]  <= csr_new;
      if (csr_wr && csr_addr_i == CSR_MCYCLEH) mcycle_q[63:32] <= csr_new;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_trap_csr_unit.sv
// Bench for rv32_trap_csr_unit: directed scenarios followed by randomized CSR
// traffic and randomized trap decisions checked against a behavioural model.
// Local line 0 is edge-triggered, the other lines are level-sensitive.
module tb_rv32_trap_csr_unit;

  localparam int NUM_IRQ = 16;

  logic               clk = 1'b0;
  logic               rst_i = 1'b1;
  logic [NUM_IRQ-1:0] irq_i = '0;
  logic               timer_irq_i = 1'b0;
  logic               csr_en_i = 1'b0;
  logic [1:0]         csr_op_i = 2'b00;
  logic [11:0]        csr_addr_i = 12'h000;
  logic [31:0]        csr_wdata_i = '0;
  logic [31:0]        csr_rdata_o;
  logic               csr_illegal_o;
  logic               trap_check_i = 1'b0;
  logic [31:0]        insn_pc_i = '0;
  logic               ecall_i = 1'b0, ebreak_i = 1'b0, mret_i = 1'b0, wfi_i = 1'b0;
  logic               trap_take_o;
  logic [31:0]        trap_pc_o, mret_pc_o, csr_mip_o, csr_mie_o;
  logic               irq_pending_o, wfi_sleep_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_trap_csr_unit #(
    .NUM_IRQ       (NUM_IRQ),
    .IRQ_EDGE_MASK (16'h0001),
    .RESET_MTVEC   (32'h0110_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .irq_i         (irq_i),
    .timer_irq_i   (timer_irq_i),
    .csr_en_i      (csr_en_i),
    .csr_op_i      (csr_op_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wdata_i   (csr_wdata_i),
    .csr_rdata_o   (csr_rdata_o),
    .csr_illegal_o (csr_illegal_o),
    .trap_check_i  (trap_check_i),
    .insn_pc_i     (insn_pc_i),
    .ecall_i       (ecall_i),
    .ebreak_i      (ebreak_i),
    .mret_i        (mret_i),
    .wfi_i         (wfi_i),
    .trap_take_o   (trap_take_o),
    .trap_pc_o     (trap_pc_o),
    .mret_pc_o     (mret_pc_o),
    .irq_pending_o (irq_pending_o),
    .wfi_sleep_o   (wfi_sleep_o),
    .csr_mip_o     (csr_mip_o),
    .csr_mie_o     (csr_mie_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_en_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
    tick();
    csr_en_i = 1'b0; csr_op_i = 2'b00;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr_i = a;
    #1;
    d = csr_rdata_o;
  endtask

  // Behavioural model of the software-visible CSR file
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch, m_mip;

  function automatic logic model_legal(input logic [11:0] a);
    return a == 12'h300 || a == 12'h304 || a == 12'h305 || a == 12'h340 ||
           a == 12'h341 || a == 12'h342 || a == 12'h344;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: m_mstatus  = v & 32'h0000_0088;
      12'h304: m_mie      = v & 32'hFFFF_0080;
      12'h305: m_mtvec    = v & 32'hFFFF_FFFD;
      12'h340: m_mscratch = v;
      12'h341: m_mepc     = v & 32'hFFFF_FFFC;
      12'h342: m_mcause   = v;
      12'h344: m_mip      = v & 32'h0001_0000;
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, nv, old_v, lines, mie_v, base, pc, mipv, elig, exp_cause, exp_pc;
    logic [11:0] addrs [10];
    logic [11:0] a;
    logic [1:0]  op;
    logic        gie, tmr, ec, eb, is_irq, take, mode;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344,
              12'h7B1, 12'h343, 12'hF11};

    // ---- reset: trap decision suppressed, reset values visible
    trap_check_i = 1'b1; ecall_i = 1'b1;
    tick(); tick();
    chk("rst_take", 32'(trap_take_o), 32'h0);
    trap_check_i = 1'b0; ecall_i = 1'b0; rst_i = 1'b0;
    csr_rd(12'h300, rd); chk("rst_mstatus", rd, 32'h0);
    csr_rd(12'h305, rd); chk("rst_mtvec", rd, 32'h0110_0000);
    csr_rd(12'h344, rd); chk("rst_mip", rd, 32'h0);
    chk("rst_sleep", 32'(wfi_sleep_o), 32'h0);
    tick();

    // ---- illegal address and masked mstatus write
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h7B1; csr_wdata_i = 32'hFFFF_FFFF;
    #1;
    chk("illegal_flag", 32'(csr_illegal_o), 32'h1);
    chk("illegal_rdata", csr_rdata_o, 32'h0);
    tick(); csr_en_i = 1'b0;
    csr_do(2'b01, 12'h340, 32'hDEAD_BEEF);
    csr_rd(12'h340, rd); chk("mscratch_rw", rd, 32'hDEAD_BEEF);
    csr_do(2'b01, 12'h300, 32'hFFFF_FFFF);
    csr_rd(12'h300, rd); chk("mstatus_mask", rd, 32'h0000_0088);
    csr_do(2'b01, 12'h300, 32'h0);

    // ---- level line 1, direct mode
    csr_do(2'b01, 12'h304, 32'h0002_0000);
    csr_do(2'b01, 12'h300, 32'h8);
    irq_i[1] = 1'b1;
    tick();
    csr_rd(12'h344, rd); chk("level_mip", rd, 32'h0002_0000);
    chk("level_pending", 32'(irq_pending_o), 32'h1);
    trap_check_i = 1'b1; insn_pc_i = 32'h0100_0042;
    #1;
    chk("level_take", 32'(trap_take_o), 32'h1);
    chk("level_pc", trap_pc_o, 32'h0110_0000);
    tick();
    trap_check_i = 1'b0; irq_i = '0;
    csr_rd(12'h342, rd); chk("level_mcause", rd, 32'h8000_0011);
    csr_rd(12'h341, rd); chk("level_mepc", rd, 32'h0100_0040);
    csr_rd(12'h300, rd); chk("level_mstatus", rd, 32'h0000_0080);
    tick();

    // ---- vectored mode: line 3 beats timer
    csr_do(2'b01, 12'h305, 32'h0110_0003);
    csr_rd(12'h305, rd); chk("mtvec_bit1", rd, 32'h0110_0001);
    csr_do(2'b01, 12'h304, 32'h0008_0080);
    csr_do(2'b01, 12'h300, 32'h8);
    irq_i[3] = 1'b1; timer_irq_i = 1'b1;
    tick();
    chk("vec_pc_line3", trap_pc_o, 32'h0110_004C);
    trap_check_i = 1'b1; insn_pc_i = 32'h0100_0080;
    #1;
    chk("vec_take", 32'(trap_take_o), 32'h1);
    tick();
    trap_check_i = 1'b0; irq_i = '0;
    csr_rd(12'h342, rd); chk("vec_mcause", rd, 32'h8000_0013);
    tick();
    csr_do(2'b01, 12'h300, 32'h8);
    chk("vec_pc_timer", trap_pc_o, 32'h0110_001C);
    timer_irq_i = 1'b0;
    csr_do(2'b01, 12'h300, 32'h0);
    csr_do(2'b01, 12'h304, 32'h0);

    // ---- edge line 0
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
    csr_rd(12'h344, rd); chk("edge_lat1", rd, 32'h0);
    tick();
    csr_rd(12'h344, rd); chk("edge_lat2", rd, 32'h0001_0000);
    tick(); tick();
    csr_rd(12'h344, rd); chk("edge_held", rd, 32'h0001_0000);
    csr_do(2'b11, 12'h344, 32'h0001_0000);
    csr_rd(12'h344, rd); chk("edge_clear", rd, 32'h0);
    csr_do(2'b10, 12'h344, 32'h0002_00A0);
    csr_rd(12'h344, rd); chk("mip_readonly", rd, 32'h0);
    irq_i[0] = 1'b1;
    tick();
    irq_i[0] = 1'b0;
    csr_do(2'b11, 12'h344, 32'h0001_0000);
    csr_rd(12'h344, rd); chk("edge_set_wins", rd, 32'h0001_0000);
    csr_do(2'b11, 12'h344, 32'h0001_0000);
    csr_rd(12'h344, rd); chk("edge_clear2", rd, 32'h0);

    // ---- ecall with MIE=0, exception uses base even in vectored mode
    csr_do(2'b01, 12'h305, 32'h0110_0001);
    trap_check_i = 1'b1; ecall_i = 1'b1; insn_pc_i = 32'h0100_0100;
    #1;
    chk("ecall_take", 32'(trap_take_o), 32'h1);
    chk("ecall_pc", trap_pc_o, 32'h0110_0000);
    tick();
    trap_check_i = 1'b0; ecall_i = 1'b0;
    csr_rd(12'h342, rd); chk("ecall_mcause", rd, 32'd11);
    chk("ecall_mret_pc", mret_pc_o, 32'h0100_0100);
    csr_rd(12'h300, rd); chk("ecall_mstatus", rd, 32'h0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    csr_rd(12'h300, rd); chk("mret_mstatus0", rd, 32'h0000_0080);

    // ---- ebreak with MIE=1, mret restores MIE
    csr_do(2'b01, 12'h300, 32'h8);
    trap_check_i = 1'b1; ebreak_i = 1'b1; insn_pc_i = 32'h0100_0200;
    #1;
    chk("ebreak_take", 32'(trap_take_o), 32'h1);
    tick();
    trap_check_i = 1'b0; ebreak_i = 1'b0;
    csr_rd(12'h342, rd); chk("ebreak_mcause", rd, 32'd3);
    csr_rd(12'h300, rd); chk("ebreak_mstatus", rd, 32'h0000_0080);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    csr_rd(12'h300, rd); chk("mret_mstatus1", rd, 32'h0000_0088);
    csr_do(2'b01, 12'h305, 32'h0110_0000);

    // ---- simultaneous events
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h300; csr_wdata_i = 32'h0;
    mret_i = 1'b1;
    tick();
    csr_en_i = 1'b0; mret_i = 1'b0;
    csr_rd(12'h300, rd); chk("mret_beats_csr", rd, 32'h0000_0088);
    csr_en_i = 1'b1; csr_op_i = 2'b01; csr_addr_i = 12'h341; csr_wdata_i = 32'h1234_5678;
    trap_check_i = 1'b1; ecall_i = 1'b1; insn_pc_i = 32'h0100_0300;
    tick();
    csr_en_i = 1'b0; trap_check_i = 1'b0; ecall_i = 1'b0;
    csr_rd(12'h341, rd); chk("trap_beats_csr", rd, 32'h0100_0300);
    csr_rd(12'h300, rd); chk("trap_mstatus", rd, 32'h0000_0080);
    tick();

    // ---- WFI wake with MIE=0, then reset mid-wait
    csr_do(2'b01, 12'h300, 32'h0);
    csr_do(2'b01, 12'h304, 32'h80);
    wfi_i = 1'b1;
    tick();
    wfi_i = 1'b0;
    chk("wfi_sleep", 32'(wfi_sleep_o), 32'h1);
    tick();
    chk("wfi_still", 32'(wfi_sleep_o), 32'h1);
    timer_irq_i = 1'b1;
    tick();
    chk("wfi_sample", 32'(wfi_sleep_o), 32'h1);
    tick();
    chk("wfi_wake", 32'(wfi_sleep_o), 32'h0);
    trap_check_i = 1'b1;
    #1;
    chk("wfi_no_trap", 32'(trap_take_o), 32'h0);
    chk("wfi_pending", 32'(irq_pending_o), 32'h1);
    trap_check_i = 1'b0; timer_irq_i = 1'b0;
    tick();
    wfi_i = 1'b1;
    tick();
    wfi_i = 1'b0;
    chk("wfi_sleep2", 32'(wfi_sleep_o), 32'h1);
    rst_i = 1'b1;
    tick();
    chk("wfi_reset", 32'(wfi_sleep_o), 32'h0);
    rst_i = 1'b0;
    csr_rd(12'h304, rd); chk("wfi_reset_mie", rd, 32'h0);
    tick();

    // ---- randomized CSR traffic against the model
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h0110_0000; m_mepc = 0;
    m_mcause = 0; m_mscratch = 0; m_mip = 0;
    for (int i = 0; i < 150; i++) begin
      a  = addrs[$urandom_range(0, 9)];
      op = 2'($urandom_range(0, 3));
      nv = $urandom;
      csr_en_i = 1'b1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = nv;
      #1;
      old_v = model_read(a);
      chk("rand_rdata", csr_rdata_o, old_v);
      chk("rand_illegal", 32'(csr_illegal_o), model_legal(a) ? 32'h0 : 32'h1);
      tick();
      csr_en_i = 1'b0;
      if (model_legal(a) && op != 2'b00)
        model_write(a, op == 2'b01 ? nv : op == 2'b10 ? (old_v | nv) : (old_v & ~nv));
    end

    // ---- randomized trap decisions against the priority rules
    for (int i = 0; i < 40; i++) begin
      mode  = 1'($urandom_range(0, 1));
      base  = $urandom & 32'hFFFF_FF00;
      csr_do(2'b01, 12'h305, base | {31'd0, mode});
      csr_do(2'b01, 12'h344, 32'h0);
      mie_v = $urandom & $urandom & 32'hFFFF_0080;
      csr_do(2'b01, 12'h304, mie_v);
      gie   = 1'($urandom_range(0, 1));
      csr_do(2'b01, 12'h300, {28'd0, gie, 3'd0});
      lines = $urandom & $urandom & 32'h0000_FFFE;
      tmr   = 1'($urandom_range(0, 1));
      irq_i = lines[15:0]; timer_irq_i = tmr;
      tick();
      ec = 1'($urandom_range(0, 1));
      eb = 1'($urandom_range(0, 1));
      pc = $urandom;
      mipv = (lines << 16) | {24'd0, tmr, 7'd0};
      elig = gie ? (mipv & mie_v) : 32'h0;
      is_irq = 1'b0; exp_cause = 32'h0;
      for (int k = 0; k < NUM_IRQ; k++)
        if (!is_irq && elig[16 + k]) begin is_irq = 1'b1; exp_cause = 32'(16 + k); end
      if (!is_irq && elig[7]) begin is_irq = 1'b1; exp_cause = 32'd7; end
      if (!is_irq) exp_cause = ec ? 32'd11 : 32'd3;
      take   = is_irq | ec | eb;
      exp_pc = (is_irq && mode) ? base + 4 * exp_cause : base;
      trap_check_i = 1'b1; ecall_i = ec; ebreak_i = eb; insn_pc_i = pc;
      #1;
      chk("rnd_take", 32'(trap_take_o), 32'(take));
      chk("rnd_pending", 32'(irq_pending_o), 32'(|(mipv & mie_v)));
      if (take) chk("rnd_pc", trap_pc_o, exp_pc);
      tick();
      trap_check_i = 1'b0; ecall_i = 1'b0; ebreak_i = 1'b0;
      irq_i = '0; timer_irq_i = 1'b0;
      if (take) begin
        csr_rd(12'h342, rd); chk("rnd_mcause", rd, {is_irq, exp_cause[30:0]});
        csr_rd(12'h341, rd); chk("rnd_mepc", rd, pc & 32'hFFFF_FFFC);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
